// File: rtl/tc_abuffer_ctrl_pkg.sv
// Shared types and geometry for the A-operand tile buffer sequencer.
package tc_abuffer_ctrl_pkg;
  localparam int M         = 16;
  localparam int K         = 16;
  localparam int TILE_M    = 4;
  localparam int TILE_K    = 4;
  localparam int ITER_M    = M / TILE_M;
  localparam int ITER_K    = K / TILE_K;
  localparam int N_ITER    = ITER_M * ITER_K;
  localparam int DW_IDX    = 4;
  localparam int DW_AW     = 32;
  localparam int ROW_BYTES = 64;
  localparam int MAX_OUTST = 4;
  localparam int CNT_W     = $clog2(M + 1);
  localparam int TM_W      = $clog2(ITER_M);
  localparam int TK_W      = $clog2(ITER_K);

  localparam logic ORDER_M_MAJOR = 1'b0;
  localparam logic ORDER_K_MAJOR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/tc_abuffer_ctrl_walker.sv
// Nested rep/tk/tm counter that walks the tile pointer in M-major or K-major order.
module tc_tile_walker
  import tc_abuffer_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic              i_order,
  input  logic [7:0]        i_rep,
  output logic [DW_IDX-1:0] o_ptr,
  output logic              o_last
);
  logic [7:0]      r_rep_cnt;
  logic [TM_W-1:0] r_tm;
  logic [TK_W-1:0] r_tk;
  logic [7:0]      w_rep_max;
  logic            w_rep_end;
  logic            w_tk_end;
  logic            w_tm_end;

  // A repeat count of zero behaves like one presentation per tile.
  assign w_rep_max = (i_rep == 8'd0) ? 8'd0 : i_rep - 8'd1;
  assign w_rep_end = (r_rep_cnt == w_rep_max);
  assign w_tk_end  = (r_tk == TK_W'(ITER_K - 1));
  assign w_tm_end  = (r_tm == TM_W'(ITER_M - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      r_rep_cnt <= 8'd0;
      r_tm      <= '0;
      r_tk      <= '0;
    end else if (i_advance) begin
      if (!w_rep_end) begin
        r_rep_cnt <= r_rep_cnt + 8'd1;
      end else begin
        r_rep_cnt <= 8'd0;
        if (i_order == ORDER_M_MAJOR) begin
          if (w_tk_end) begin
            r_tk <= '0;
            r_tm <= w_tm_end ? '0 : r_tm + TM_W'(1);
          end else begin
            r_tk <= r_tk + TK_W'(1);
          end
        end else begin
          if (w_tm_end) begin
            r_tm <= '0;
            r_tk <= w_tk_end ? '0 : r_tk + TK_W'(1);
          end else begin
            r_tm <= r_tm + TM_W'(1);
          end
        end
      end
    end
  end

  assign o_ptr  = DW_IDX'(int'(r_tm) * ITER_K + int'(r_tk));
  assign o_last = w_rep_end && w_tk_end && w_tm_end;
endmodule

// File: rtl/tc_abuffer_ctrl.sv
// A-operand tile buffer sequencer: loads M rows from memory, then presents every tile.
// state | meaning
// IDLE  | waiting for start;  LOAD  | issuing row reads, writing responses
// DRAIN | presenting tiles;   DONE  | one-cycle completion pulse
module tc_abuffer_ctrl
  import tc_abuffer_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DW_AW-1:0]  i_cfg_base,
  input  logic              i_cfg_order,
  input  logic [7:0]        i_cfg_rep,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [DW_AW-1:0]  o_mem_req_addr,
  input  logic              i_mem_rsp_valid,
  output logic              o_buf_write_en,
  output logic [DW_IDX-1:0] o_buf_row_in,
  output logic [DW_IDX-1:0] o_buf_ptr_out,
  output logic              o_tile_valid,
  input  logic              i_tile_ready,
  output logic              o_tile_last,
  output logic              o_busy,
  output logic              o_done
);
  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_req_cnt;
  logic [CNT_W-1:0]   r_rsp_cnt;
  logic [DW_AW-1:0]   r_base;
  logic               r_order;
  logic [7:0]         r_rep;
  logic [CNT_W-1:0]   w_outst;
  logic [DW_IDX-1:0]  w_ptr;
  logic               w_last;
  logic               w_walk_clear;
  logic               w_tile_hs;

  assign w_outst      = r_req_cnt - r_rsp_cnt;
  assign w_walk_clear = (r_state != ST_DRAIN);
  assign w_tile_hs    = o_tile_valid && i_tile_ready;

  tc_tile_walker u_walker (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_walk_clear),
    .i_advance (w_tile_hs),
    .i_order   (r_order),
    .i_rep     (r_rep),
    .o_ptr     (w_ptr),
    .o_last    (w_last)
  );

  always_comb begin
    w_next          = r_state;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    o_buf_write_en  = 1'b0;
    o_buf_row_in    = '0;
    o_buf_ptr_out   = '0;
    o_tile_valid    = 1'b0;
    o_tile_last     = 1'b0;
    o_done          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        o_mem_req_valid = (r_req_cnt < CNT_W'(M)) && (w_outst < CNT_W'(MAX_OUTST));
        o_mem_req_addr  = r_base + DW_AW'(r_req_cnt) * DW_AW'(ROW_BYTES);
        o_buf_write_en  = i_mem_rsp_valid;
        o_buf_row_in    = r_rsp_cnt[DW_IDX-1:0];
        if (i_mem_rsp_valid && (r_rsp_cnt == CNT_W'(M - 1))) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_tile_valid  = 1'b1;
        o_buf_ptr_out = w_ptr;
        o_tile_last   = w_last;
        if (i_tile_ready && w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
      r_base    <= '0;
      r_order   <= 1'b0;
      r_rep     <= 8'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && i_start) begin
        r_base    <= i_cfg_base;
        r_order   <= i_cfg_order;
        r_rep     <= i_cfg_rep;
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
      end else begin
        if (o_mem_req_valid && i_mem_req_ready) r_req_cnt <= r_req_cnt + CNT_W'(1);
        if (o_buf_write_en) r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_tc_abuffer_ctrl.sv
// Self-checking bench for tc_abuffer_ctrl: job table plus scoreboard queues.
module tb_tc_abuffer_ctrl;
  import tc_abuffer_ctrl_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_reset, i_start, i_cfg_order, i_mem_req_ready, i_mem_rsp_valid, i_tile_ready;
  logic [DW_AW-1:0]  i_cfg_base;
  logic [7:0]        i_cfg_rep;
  logic              o_mem_req_valid, o_buf_write_en, o_tile_valid, o_tile_last, o_busy, o_done;
  logic [DW_AW-1:0]  o_mem_req_addr;
  logic [DW_IDX-1:0] o_buf_row_in, o_buf_ptr_out;

  always #5 i_clk = ~i_clk;

  tc_abuffer_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_cfg_base(i_cfg_base), .i_cfg_order(i_cfg_order), .i_cfg_rep(i_cfg_rep),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_addr(o_mem_req_addr), .i_mem_rsp_valid(i_mem_rsp_valid),
    .o_buf_write_en(o_buf_write_en), .o_buf_row_in(o_buf_row_in),
    .o_buf_ptr_out(o_buf_ptr_out), .o_tile_valid(o_tile_valid),
    .i_tile_ready(i_tile_ready), .o_tile_last(o_tile_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct {
    logic [31:0] base;
    logic        order;
    logic [7:0]  rep;
    bit          req_toggle;
    int          rsp_delay;
    bit          stall6;
    bit          start_in_drain;
    int          abort_after;
    int          exp_pres;
    int          exp_done;
  } job_t;

  job_t        jobs[7];
  job_t        cj;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] q_addr[$];
  int          q_row[$];
  int          q_ptr[$];
  int          mq[$];
  int          cyc = 0;
  int          stall_left, accepted, delivered, pres_cnt, done_cnt, rsp_seen, last_hs_cyc;
  bit          start_pend, reset_pend, extra_started, aborted, abort_chk;
  bit          prev_req_stall, prev_tile_stall;
  logic [31:0] prev_addr;
  logic [3:0]  prev_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive();
    i_start = start_pend;
    start_pend = 1'b0;
    if (cj.start_in_drain && !extra_started && o_tile_valid) begin
      i_start = 1'b1;
      extra_started = 1'b1;
    end
    i_reset = !reset_pend;
    reset_pend = 1'b0;
    i_mem_req_ready = cj.req_toggle ? ((cyc % 2) == 0) : 1'b1;
    if (mq.size() > 0 && mq[0] <= cyc) begin
      i_mem_rsp_valid = 1'b1;
      void'(mq.pop_front());
    end else begin
      i_mem_rsp_valid = 1'b0;
    end
    if (stall_left > 0) begin
      i_tile_ready = 1'b0;
      stall_left--;
    end else begin
      i_tile_ready = 1'b1;
    end
  endtask

  task automatic monitor();
    if (abort_chk) begin
      check("abort_busy", 64'(o_busy), 64'(0));
      abort_chk = 1'b0;
    end
    if (!i_reset) abort_chk = 1'b1;
    if (!o_busy)
      check("idle_quiet", 64'({o_mem_req_valid, o_buf_write_en, o_tile_valid, o_tile_last,
                               o_buf_ptr_out, o_done}), 64'(0));
    if (prev_req_stall) begin
      check("req_hold_valid", 64'(o_mem_req_valid), 64'(1));
      check("req_hold_addr", 64'(o_mem_req_addr), 64'(prev_addr));
    end
    if (o_mem_req_valid) check("outstanding_ok", 64'((accepted - delivered) < MAX_OUTST), 64'(1));
    if (o_mem_req_valid && i_mem_req_ready) begin
      if (q_addr.size() == 0) check("req_unexpected", 64'(o_mem_req_valid), 64'(0));
      else check("req_addr", 64'(o_mem_req_addr), 64'(q_addr.pop_front()));
      accepted++;
      mq.push_back(cyc + cj.rsp_delay);
    end
    prev_req_stall = o_mem_req_valid && !i_mem_req_ready;
    prev_addr = o_mem_req_addr;
    if (i_mem_rsp_valid) delivered++;
    if (o_buf_write_en) begin
      rsp_seen++;
      if (q_row.size() == 0) check("row_unexpected", 64'(o_buf_write_en), 64'(0));
      else check("row_in", 64'(o_buf_row_in), 64'(q_row.pop_front()));
      if (cj.abort_after > 0 && rsp_seen == cj.abort_after && !aborted) begin
        reset_pend = 1'b1;
        aborted = 1'b1;
      end
    end
    if (prev_tile_stall) begin
      check("tile_hold_valid", 64'(o_tile_valid), 64'(1));
      check("tile_hold_ptr", 64'(o_buf_ptr_out), 64'(prev_ptr));
    end
    if (o_tile_valid && i_tile_ready) begin
      pres_cnt++;
      if (q_ptr.size() == 0) check("tile_unexpected", 64'(o_tile_valid), 64'(0));
      else begin
        check("ptr", 64'(o_buf_ptr_out), 64'(q_ptr.pop_front()));
        check("tile_last", 64'(o_tile_last), 64'(q_ptr.size() == 0));
      end
      last_hs_cyc = cyc;
      if (cj.stall6 && o_buf_ptr_out == 4'd5) stall_left = 5;
    end
    prev_tile_stall = o_tile_valid && !i_tile_ready;
    prev_ptr = o_buf_ptr_out;
    if (o_done) begin
      done_cnt++;
      check("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
    drive();
    @(negedge i_clk);
    monitor();
  endtask

  task automatic run_job(input int j);
    int reps;
    cj = jobs[j];
    q_addr.delete(); q_row.delete(); q_ptr.delete();
    accepted = 0; delivered = 0; pres_cnt = 0; done_cnt = 0; rsp_seen = 0;
    stall_left = 0; extra_started = 1'b0; aborted = 1'b0; last_hs_cyc = -10;
    i_cfg_base = cj.base;
    i_cfg_order = cj.order;
    i_cfg_rep = cj.rep;
    reps = (cj.rep == 8'd0) ? 1 : int'(cj.rep);
    for (int i = 0; i < M; i++) begin
      q_addr.push_back(cj.base + 32'(i * ROW_BYTES));
      q_row.push_back(i);
    end
    if (cj.order == 1'b0) begin
      for (int tm = 0; tm < ITER_M; tm++)
        for (int tk = 0; tk < ITER_K; tk++)
          for (int r = 0; r < reps; r++) q_ptr.push_back(tm * ITER_K + tk);
    end else begin
      for (int tk = 0; tk < ITER_K; tk++)
        for (int tm = 0; tm < ITER_M; tm++)
          for (int r = 0; r < reps; r++) q_ptr.push_back(tm * ITER_K + tk);
    end
    start_pend = 1'b1;
    for (int b = 0; b < 3000 && !(done_cnt > 0 || (aborted && !o_busy)); b++) step();
    repeat (5) step();
    for (int b = 0; b < 200 && mq.size() > 0; b++) step();
    check("pres_count", 64'(pres_cnt), 64'(cj.exp_pres));
    check("done_count", 64'(done_cnt), 64'(cj.exp_done));
    check("busy_after", 64'(o_busy), 64'(0));
    if (cj.abort_after == 0) begin
      check("addr_left", 64'(q_addr.size()), 64'(0));
      check("rows_left", 64'(q_row.size()), 64'(0));
      check("ptr_left", 64'(q_ptr.size()), 64'(0));
    end
  endtask

  initial begin
    //         base          ord  rep  tgl dly st6 sid abort pres done
    jobs[0] = '{32'h0000_1000, 1'b0, 8'd1, 1'b0, 2, 1'b0, 1'b0, 0, 16, 1};
    jobs[1] = '{32'h0000_2000, 1'b1, 8'd2, 1'b0, 2, 1'b0, 1'b0, 0, 32, 1};
    jobs[2] = '{32'h0000_0000, 1'b0, 8'd1, 1'b1, 10, 1'b0, 1'b0, 0, 16, 1};
    jobs[3] = '{32'h0000_3000, 1'b0, 8'd1, 1'b0, 2, 1'b1, 1'b0, 0, 16, 1};
    jobs[4] = '{32'h0000_4000, 1'b0, 8'd0, 1'b0, 3, 1'b0, 1'b1, 0, 16, 1};
    jobs[5] = '{32'h0000_5000, 1'b0, 8'd1, 1'b0, 2, 1'b0, 1'b0, 7, 0, 0};
    jobs[6] = '{32'h0000_6000, 1'b1, 8'd3, 1'b1, 4, 1'b0, 1'b0, 0, 48, 1};
    cj = jobs[0];
    i_reset = 1'b0; i_start = 1'b0; i_cfg_base = '0; i_cfg_order = 1'b0; i_cfg_rep = 8'd0;
    i_mem_req_ready = 1'b1; i_mem_rsp_valid = 1'b0; i_tile_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b1;
    @(negedge i_clk);
    check("reset_busy", 64'(o_busy), 64'(0));
    check("reset_outputs", 64'({o_mem_req_valid, o_mem_req_addr, o_buf_write_en, o_buf_row_in,
                                o_buf_ptr_out, o_tile_valid, o_tile_last, o_done}), 64'(0));
    for (int j = 0; j < 7; j++) run_job(j);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
